// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU     = 1'b0;
  localparam logic REQ_DBG     = 1'b1;
  localparam int   MEM_LAT_MAX = 4;
  localparam int   CNT_W       = 3;

  // Requester ID to one-hot {dbg, cpu} vector.
  function automatic logic [1:0] id_to_onehot(input logic id);
    if (id == REQ_DBG) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, debug port and memory-side signals of dmem_arbiter.
// The arbiter uses the slave modport; requesters and memory use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_rr2.sv
// Two-way request picker returning a one-hot {dbg, cpu} grant.
// DMEM_ARB_DBG_PRIO_EN selects fixed debug priority instead of round-robin.
module dmem_arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Contention goes to the port that did not complete last.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
`ifdef DMEM_ARB_DBG_PRIO_EN
      gnt = id_to_onehot(REQ_DBG);
`else
      gnt = id_to_onehot(~ptr);
`endif
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing the single-port data memory between the CPU and
// debug ports. Define DMEM_ARB_DBG_PRIO_EN to give debug fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_q, win_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic [1:0]        req_s, pick_s, gnt_s, done_s;
  logic              pick_id_s, ptr_s;
  logic              mem_en_s, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign req_s     = {bus.dbg_req, bus.cpu_req};
  assign pick_id_s = pick_s[1];

  dmem_arb_rr2 u_rr2 (
    .req (req_s),
    .ptr (ptr_s),
    .gnt (pick_s)
  );

`ifdef DMEM_ARB_DBG_PRIO_EN
  assign ptr_s = REQ_DBG;
`else
  logic ptr_q, ptr_d;

  assign ptr_s = ptr_q;

  // Remember which port completed last; reset favours the CPU on first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_DBG;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) begin
      ptr_d = win_q;
    end else begin
      ptr_d = ptr_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= REQ_CPU;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      resp_q  <= resp_d;
    end
  end

  // Issue is combinational in IDLE so the grant costs no cycle; held off in reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    resp_d      = resp_q;
    gnt_s       = 2'b00;
    done_s      = 2'b00;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    case (state_q)
      IDLE: begin
        if ((req_s != 2'b00) && !rst) begin
          gnt_s    = pick_s;
          mem_en_s = 1'b1;
          win_d    = pick_id_s;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = WAIT;
          if (pick_id_s == REQ_DBG) begin
            mem_we_s    = bus.dbg_we;
            mem_addr_s  = bus.dbg_addr;
            mem_wdata_s = bus.dbg_wdata;
          end else begin
            mem_we_s    = bus.cpu_we;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          resp_d  = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        done_s  = id_to_onehot(win_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cpu_gnt   = gnt_s[0];
  assign bus.dbg_gnt   = gnt_s[1];
  assign bus.cpu_done  = done_s[0];
  assign bus.dbg_done  = done_s[1];
  assign bus.cpu_rdata = resp_q;
  assign bus.dbg_rdata = resp_q;
  assign bus.cpu_stall = bus.cpu_req & ~done_s[0];
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 4) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } rq_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] cpu_rdata;
    logic [63:0] dbg_rdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) u_dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a.slave));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B)) u_dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b.slave));

  // Memory contents as a fixed function of the address.
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h40) return 64'hDEAD_BEEF_0000_0001;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[63:32]};
  endfunction

  // Memory: read data appears exactly MEM_LAT cycles after mem_en, noise otherwise.
  logic [64:0] pipe_a [LAT_A];
  logic [64:0] pipe_b [LAT_B];
  logic [63:0] noise_q;
  always @(posedge clk) begin
    noise_q   <= {$urandom, $urandom};
    pipe_a[0] <= {bus_a.mem_en & ~bus_a.mem_we, mem_fn(bus_a.mem_addr)};
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= {bus_b.mem_en & ~bus_b.mem_we, mem_fn(bus_b.mem_addr)};
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign bus_a.mem_rdata = pipe_a[LAT_A-1][64] ? pipe_a[LAT_A-1][63:0] : noise_q;
  assign bus_b.mem_rdata = pipe_b[LAT_B-1][64] ? pipe_b[LAT_B-1][63:0] : noise_q;

  rq_t         rq      [2][2];
  obs_t        ob      [2];
  logic        rst_v   [2];
  logic        act     [2];
  logic        port    [2];
  logic        st_we   [2];
  logic        last    [2];
  int          done_at [2];
  logic [63:0] exp_rd  [2];
  logic        pend    [2][2];
  int          n_cmp, n_bad, cyc;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic apply();
    rst_a = rst_v[0];
    rst_b = rst_v[1];
    bus_a.cpu_req = rq[0][0].req; bus_a.cpu_we = rq[0][0].we;
    bus_a.cpu_addr = rq[0][0].addr; bus_a.cpu_wdata = rq[0][0].wdata;
    bus_a.dbg_req = rq[0][1].req; bus_a.dbg_we = rq[0][1].we;
    bus_a.dbg_addr = rq[0][1].addr; bus_a.dbg_wdata = rq[0][1].wdata;
    bus_b.cpu_req = rq[1][0].req; bus_b.cpu_we = rq[1][0].we;
    bus_b.cpu_addr = rq[1][0].addr; bus_b.cpu_wdata = rq[1][0].wdata;
    bus_b.dbg_req = rq[1][1].req; bus_b.dbg_we = rq[1][1].we;
    bus_b.dbg_addr = rq[1][1].addr; bus_b.dbg_wdata = rq[1][1].wdata;
  endtask

  task automatic sample();
    ob[0] = {bus_a.dbg_gnt, bus_a.cpu_gnt, bus_a.dbg_done, bus_a.cpu_done, bus_a.cpu_stall,
             bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
             bus_a.cpu_rdata, bus_a.dbg_rdata};
    ob[1] = {bus_b.dbg_gnt, bus_b.cpu_gnt, bus_b.dbg_done, bus_b.cpu_done, bus_b.cpu_stall,
             bus_b.mem_en, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata,
             bus_b.cpu_rdata, bus_b.dbg_rdata};
  endtask

  // Transaction-level model: one access at a time, done LAT+1 cycles after issue.
  task automatic model_check(input int l);
    obs_t       e;
    logic [1:0] r;
    logic       w, fin;
    int         lat;
    lat = (l == 0) ? LAT_A : LAT_B;
    e   = '0;
    fin = 1'b0;
    w   = 1'b0;
    r   = {rq[l][1].req, rq[l][0].req};
    if (rst_v[l]) begin
      act[l] = 1'b0;
      last[l] = REQ_DBG;
      pend[l][0] = 1'b0;
      pend[l][1] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (pend[l][p]) chk($sformatf("L%0d p%0d req held until done", l, p), r[p], 1'b1);
      if (act[l] && cyc == done_at[l]) begin
        e.done = id_to_onehot(port[l]);
        fin = 1'b1;
      end else if (!act[l] && r != 2'b00) begin
        if (r == 2'b11) begin
`ifdef DMEM_ARB_DBG_PRIO_EN
          w = REQ_DBG;
`else
          w = ~last[l];
`endif
        end else begin
          w = r[1];
        end
        e.gnt       = id_to_onehot(w);
        e.mem_en    = 1'b1;
        e.mem_we    = rq[l][w].we;
        e.mem_addr  = rq[l][w].addr;
        e.mem_wdata = rq[l][w].wdata;
        act[l]      = 1'b1;
        port[l]     = w;
        st_we[l]    = rq[l][w].we;
        done_at[l]  = cyc + lat + 1;
        exp_rd[l]   = mem_fn(rq[l][w].addr);
      end
    end
    e.stall = r[0] & ~e.done[0];
    chk($sformatf("L%0d gnt", l), ob[l].gnt, e.gnt);
    chk($sformatf("L%0d done", l), ob[l].done, e.done);
    chk($sformatf("L%0d cpu_stall", l), ob[l].stall, e.stall);
    chk($sformatf("L%0d mem_en", l), ob[l].mem_en, e.mem_en);
    chk($sformatf("L%0d mem_we", l), ob[l].mem_we, e.mem_we);
    chk($sformatf("L%0d mem_addr", l), ob[l].mem_addr, e.mem_addr);
    chk($sformatf("L%0d mem_wdata", l), ob[l].mem_wdata, e.mem_wdata);
    if (rst_v[l]) begin
      chk($sformatf("L%0d cpu_rdata reset", l), ob[l].cpu_rdata, 64'h0);
      chk($sformatf("L%0d dbg_rdata reset", l), ob[l].dbg_rdata, 64'h0);
    end else if (fin && !st_we[l]) begin
      chk($sformatf("L%0d rdata", l), port[l] ? ob[l].dbg_rdata : ob[l].cpu_rdata, exp_rd[l]);
    end
    if (!rst_v[l]) begin
      for (int p = 0; p < 2; p++)
        if (fin && port[l] == p[0]) pend[l][p] = 1'b0;
        else if (r[p]) pend[l][p] = 1'b1;
    end
    if (fin) begin
      last[l] = port[l];
      act[l]  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    sample();
    model_check(0);
    model_check(1);
    cyc++;
  endtask

  task automatic set_req(input int l, input int p, input logic we, input logic [63:0] a,
                         input logic [63:0] d);
    rq[l][p] = '{req: 1'b1, we: we, addr: a, wdata: d};
  endtask

  task automatic clr_req(input int l, input int p);
    rq[l][p].req = 1'b0;
  endtask

  task automatic new_req(input int l, input int p);
    logic [63:0] a;
    a = ($urandom_range(3, 0) == 0) ? 64'h40 : {$urandom, $urandom};
    set_req(l, p, 1'($urandom_range(1, 0)), a, {$urandom, $urandom});
  endtask

  task automatic drive_rand(input int l);
    for (int p = 0; p < 2; p++) begin
      if (ob[l].done[p]) begin
        if ($urandom_range(1, 0) == 1) new_req(l, p);
        else clr_req(l, p);
      end else if (!rq[l][p].req && $urandom_range(2, 0) == 0) begin
        new_req(l, p);
      end
    end
    rst_v[l] = ($urandom_range(149, 0) == 0);
  endtask

  int   gport[$];
  int   gcyc[$];
  logic stall_all;
  int   k_done, k_dgnt;
  logic [63:0] rd_seen;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    for (int l = 0; l < 2; l++) begin
      rst_v[l] = 1'b1; act[l] = 1'b0; last[l] = REQ_DBG; done_at[l] = 0;
      for (int p = 0; p < 2; p++) begin
        rq[l][p] = '0;
        pend[l][p] = 1'b0;
      end
    end
    apply();
    repeat (3) step();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    repeat (2) step();

    // CPU load of 0x40, MEM_LAT=1
    set_req(0, 0, 1'b0, 64'h40, 64'h0);
    step();
    chk("A gnt at T", ob[0].gnt, 2'b01);
    chk("A mem_addr at T", ob[0].mem_addr, 64'h40);
    chk("A mem_we at T", ob[0].mem_we, 1'b0);
    chk("A stall at T", ob[0].stall, 1'b1);
    step();
    chk("A stall at T+1", ob[0].stall, 1'b1);
    chk("A done at T+1", ob[0].done, 2'b00);
    step();
    chk("A cpu_done at T+2", ob[0].done, 2'b01);
    chk("A cpu_rdata at T+2", ob[0].cpu_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("A stall at T+2", ob[0].stall, 1'b0);
    clr_req(0, 0);
    step();

    // Debug store of 0x1234 to 0x80
    set_req(0, 1, 1'b1, 64'h80, 64'h1234);
    step();
    chk("B gnt at T", ob[0].gnt, 2'b10);
    chk("B mem_en/we at T", {ob[0].mem_en, ob[0].mem_we}, 2'b11);
    chk("B mem_wdata at T", ob[0].mem_wdata, 64'h1234);
    step();
    chk("B mem_en at T+1", ob[0].mem_en, 1'b0);
    step();
    chk("B dbg_done at T+2", ob[0].done, 2'b10);
    clr_req(0, 1);
    step();

    // Continuous contention straight after reset
    rst_v[0] = 1'b1; step(); rst_v[0] = 1'b0;
    set_req(0, 0, 1'b0, 64'h100, 64'h0);
    set_req(0, 1, 1'b0, 64'h200, 64'h0);
    stall_all = 1'b1;
    for (int k = 0; k < 4 * (LAT_A + 2); k++) begin
      step();
      if (ob[0].gnt != 2'b00) begin
        gport.push_back(int'(ob[0].gnt[1]));
        gcyc.push_back(k);
      end
      stall_all = stall_all & ob[0].stall;
    end
    chk("C grant count", gport.size(), 4);
    for (int i = 0; i < gport.size() && i < 4; i++) begin
`ifdef DMEM_ARB_DBG_PRIO_EN
      chk($sformatf("C grant %0d port", i), gport[i], 1);
`else
      chk($sformatf("C grant %0d port", i), gport[i], i % 2);
`endif
      chk($sformatf("C grant %0d cycle", i), gcyc[i], i * (LAT_A + 2));
    end
`ifdef DMEM_ARB_DBG_PRIO_EN
    chk("C stall always high", stall_all, 1'b1);
`else
    chk("C stall always high", stall_all, 1'b0);
`endif
    clr_req(0, 0); clr_req(0, 1);
    rst_v[0] = 1'b1; step(); rst_v[0] = 1'b0;
    step();

    // MEM_LAT=4: CPU load, debug raised at T+1
    set_req(1, 0, 1'b0, 64'h40, 64'h0);
    step();
    chk("D cpu gnt at T", ob[1].gnt, 2'b01);
    set_req(1, 1, 1'b0, 64'h88, 64'h0);
    k_done = -1; k_dgnt = -1; rd_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ob[1].done[0] && k_done < 0) begin
        k_done = k;
        rd_seen = ob[1].cpu_rdata;
      end
      if (ob[1].gnt[1] && k_dgnt < 0) k_dgnt = k;
      if (ob[1].done[0]) clr_req(1, 0);
      if (ob[1].done[1]) clr_req(1, 1);
    end
    chk("D cpu_done offset", k_done, 5);
    chk("D cpu_rdata", rd_seen, 64'hDEAD_BEEF_0000_0001);
    chk("D dbg gnt offset", k_dgnt, 6);

    // Reset pulsed at T+1 of a CPU load
    set_req(0, 0, 1'b0, 64'h40, 64'h0);
    step();
    chk("E gnt at T", ob[0].gnt, 2'b01);
    rst_v[0] = 1'b1;
    step();
    chk("E outputs in reset", {ob[0].gnt, ob[0].done, ob[0].mem_en, ob[0].mem_we}, 6'd0);
    chk("E cpu_rdata in reset", ob[0].cpu_rdata, 64'h0);
    rst_v[0] = 1'b0;
    step();
    chk("E regrant after reset", ob[0].gnt, 2'b01);
    step();
    step();
    chk("E done after regrant", ob[0].done, 2'b01);
    clr_req(0, 0);
    step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive_rand(0);
      drive_rand(1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
